// File: rtl/match_sequencer_pkg.sv
// rtl/match_sequencer_pkg.sv - shared match state, winner and serve direction encodings
package match_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_GOAL   = 3'd3,
        ST_PAUSED = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

endpackage

// File: rtl/match_sequencer_frame_tick_gen.sv
// rtl/match_sequencer_frame_tick_gen.sv - free-running divider producing a registered frame step pulse
module frame_tick_gen #(
    parameter int CLK_DIV = 833333
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/match_sequencer.sv
// rtl/match_sequencer.sv - round/match controller: serve timing, scoring, pause and winner
module match_sequencer
    import match_sequencer_pkg::*;
#(
    parameter int CLK_DIV      = 833333,
    parameter int SERVE_FRAMES = 60,
    parameter int PAUSE_FRAMES = 90,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       goal_l,
    input  logic       goal_r,
    output logic       frame_tick,
    output logic       puck_run,
    output logic       puck_center,
    output logic       serve_dir,
    output logic [2:0] score_l,
    output logic [2:0] score_r,
    output logic [1:0] winner,
    output logic [2:0] game_state
);

    localparam int MAXF = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
    localparam int CW   = $clog2(MAXF + 1);
    localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_FRAMES);
    localparam logic [CW-1:0] PAUSE_LOAD = CW'(PAUSE_FRAMES);
    localparam logic [2:0]    WIN        = 3'(WIN_SCORE);

    state_t        state, state_nx;
    logic [CW-1:0] cd, cd_nx;
    logic [2:0]    score_l_nx, score_r_nx;
    logic [1:0]    winner_nx;
    logic          serve_dir_nx;
    logic          start_q, pause_q;
    logic          start_ev, pause_ev;

    frame_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (frame_tick)
    );

    assign start_ev = start & ~start_q;
    assign pause_ev = pause & ~pause_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cd        <= '0;
            score_l   <= 3'd0;
            score_r   <= 3'd0;
            winner    <= WIN_NONE;
            serve_dir <= SERVE_RIGHT;
            start_q   <= 1'b0;
            pause_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            cd        <= cd_nx;
            score_l   <= score_l_nx;
            score_r   <= score_r_nx;
            winner    <= winner_nx;
            serve_dir <= serve_dir_nx;
            start_q   <= start;
            pause_q   <= pause;
        end
    end

    always_comb begin
        state_nx     = state;
        cd_nx        = cd;
        score_l_nx   = score_l;
        score_r_nx   = score_r;
        winner_nx    = winner;
        serve_dir_nx = serve_dir;
        case (state)
            ST_IDLE: begin
                if (start_ev) begin
                    state_nx = ST_SERVE;
                    cd_nx    = SERVE_LOAD;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    cd_nx = cd - 1'b1;
                    if (cd == 1) state_nx = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // the conceding player receives the next serve
                if (goal_l && !goal_r) begin
                    score_r_nx   = score_r + 3'd1;
                    serve_dir_nx = SERVE_LEFT;
                    state_nx     = ST_GOAL;
                    cd_nx        = PAUSE_LOAD;
                end else if (goal_r && !goal_l) begin
                    score_l_nx   = score_l + 3'd1;
                    serve_dir_nx = SERVE_RIGHT;
                    state_nx     = ST_GOAL;
                    cd_nx        = PAUSE_LOAD;
                end else if (pause_ev && !goal_l && !goal_r) begin
                    state_nx = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (pause_ev) state_nx = ST_PLAY;
            end
            ST_GOAL: begin
                if (frame_tick) begin
                    cd_nx = cd - 1'b1;
                    if (cd == 1) begin
                        if (score_l == WIN || score_r == WIN) begin
                            state_nx  = ST_OVER;
                            winner_nx = (score_l == WIN) ? WIN_LEFT : WIN_RIGHT;
                        end else begin
                            state_nx = ST_SERVE;
                            cd_nx    = SERVE_LOAD;
                        end
                    end
                end
            end
            ST_OVER: begin
                if (start_ev) begin
                    score_l_nx   = 3'd0;
                    score_r_nx   = 3'd0;
                    winner_nx    = WIN_NONE;
                    serve_dir_nx = SERVE_RIGHT;
                    state_nx     = ST_SERVE;
                    cd_nx        = SERVE_LOAD;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign game_state  = state;
    assign puck_run    = (state == ST_PLAY);
    assign puck_center = (state == ST_IDLE) || (state == ST_SERVE) || (state == ST_OVER);

endmodule
